// File: rtl/cube_host_pkg.sv
// Shared types for the cube solver host sequencer: FSM encoding, widths and move codes.
package cube_host_pkg;

  localparam int MOVE_W  = 4;
  localparam int STATE_W = 120;

  typedef logic [MOVE_W-1:0]  move_t;
  typedef logic [STATE_W-1:0] cube_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STORE,
    S_SETTLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  // Move codes understood by change_cube: clockwise turn, then its inverse, per face.
  typedef enum logic [MOVE_W-1:0] {
    MV_NOP = 4'd0,
    MV_U   = 4'd1,
    MV_UI  = 4'd2,
    MV_D   = 4'd3,
    MV_DI  = 4'd4,
    MV_L   = 4'd5,
    MV_LI  = 4'd6,
    MV_R   = 4'd7,
    MV_RI  = 4'd8,
    MV_F   = 4'd9,
    MV_FI  = 4'd10,
    MV_B   = 4'd11,
    MV_BI  = 4'd12
  } move_e;

endpackage

// File: rtl/move_fifo.sv
// First-word fall-through FIFO holding the queued move codes; head is always on dout.
module move_fifo
  import cube_host_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  logic  flush,
  input  move_t din,
  output move_t dout,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  move_t          mem [DEPTH];
  logic  [AW:0]   wr_ptr_q, wr_ptr_d;
  logic  [AW:0]   rd_ptr_q, rd_ptr_d;
  logic           do_push;
  logic           do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cube_host.sv
// Host-side sequencer for the cube core: loads a start state, replays buffered moves
// through the core handshake and reports the finish flag and final state.
module cube_host
  import cube_host_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int TIMEOUT     = 255,
  parameter bit STOP_ON_FIN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [STATE_W-1:0]       init_state,
  input  logic                     mv_wr,
  input  logic [MOVE_W-1:0]        mv_data,
  output logic                     mv_full,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     solved,
  output logic                     error,
  output logic [$clog2(DEPTH):0]   moves_done,
  output logic [STATE_W-1:0]       final_state,
  output logic                     cb_store,
  output logic [STATE_W-1:0]       cb_store_data,
  output logic                     cb_load,
  output logic [MOVE_W-1:0]        cb_d,
  input  logic                     cb_valid,
  input  logic                     cb_fin,
  input  logic [STATE_W-1:0]       cb_q
);

  localparam int              CW     = $clog2(DEPTH) + 1;
  localparam int              TW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   MD_MAX = CW'(DEPTH);
  localparam logic [TW-1:0]   TMO    = TW'(TIMEOUT);

  state_e          state_q, state_d;
  cube_t           init_q, init_d;
  move_t           dhold_q, dhold_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            got_q, got_d;
  logic            solved_q, solved_d;
  logic            error_q, error_d;
  logic [CW-1:0]   mdone_q, mdone_d;
  cube_t           fstate_q, fstate_d;

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_flush;
  logic            fifo_full;
  logic            fifo_empty;
  move_t           fifo_head;

  assign fifo_push = mv_wr && (state_q == S_IDLE);

  move_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (mv_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    init_d     = init_q;
    dhold_d    = dhold_q;
    tmo_d      = tmo_q;
    got_d      = 1'b0;
    solved_d   = solved_q;
    error_d    = error_q;
    mdone_d    = mdone_q;
    fstate_d   = fstate_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    cb_store   = 1'b0;
    cb_load    = 1'b0;
    cb_d       = MV_NOP;
    done       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          solved_d = 1'b0;
          error_d  = 1'b0;
          mdone_d  = '0;
          // A write arriving with start still counts as buffer content.
          if (fifo_empty && !mv_wr) begin
            state_d = S_DONE;
          end else begin
            init_d  = init_state;
            state_d = S_STORE;
          end
        end
      end
      S_STORE: begin
        cb_store = 1'b1;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cb_load = 1'b1;
        cb_d    = fifo_head;
        dhold_d = fifo_head;
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cb_d = dhold_q;
        if (got_q) begin
          // Decision cycle after a response: the pop has landed and solved_q holds cb_fin.
          if (fifo_empty || (STOP_ON_FIN && solved_q)) begin
            fifo_flush = 1'b1;
            state_d    = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end else if (cb_valid) begin
          fstate_d = cb_q;
          solved_d = cb_fin;
          fifo_pop = 1'b1;
          got_d    = 1'b1;
          if (mdone_q != MD_MAX) mdone_d = mdone_q + 1'b1;
        end else if (tmo_q == TMO) begin
          error_d    = 1'b1;
          fifo_flush = 1'b1;
          state_d    = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      init_q   <= '0;
      dhold_q  <= '0;
      tmo_q    <= '0;
      got_q    <= 1'b0;
      solved_q <= 1'b0;
      error_q  <= 1'b0;
      mdone_q  <= '0;
      fstate_q <= '0;
    end else begin
      state_q  <= state_d;
      init_q   <= init_d;
      dhold_q  <= dhold_d;
      tmo_q    <= tmo_d;
      got_q    <= got_d;
      solved_q <= solved_d;
      error_q  <= error_d;
      mdone_q  <= mdone_d;
      fstate_q <= fstate_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign mv_full       = fifo_full;
  assign solved        = solved_q;
  assign error         = error_q;
  assign moves_done    = mdone_q;
  assign final_state   = fstate_q;
  assign cb_store_data = init_q;

endmodule

// File: tb/tb_cube_host.sv
// Randomized scoreboard bench for cube_host with a behavioural cube-core responder.
module tb_cube_host;
  import cube_host_pkg::*;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 10;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [119:0]       init_state = '0;
  logic               mv_wr = 1'b0;
  logic [3:0]         mv_data = '0;
  logic               mv_full;
  logic               start = 1'b0;
  logic               busy, done, solved, error;
  logic [CW-1:0]      moves_done;
  logic [119:0]       final_state;
  logic               cb_store;
  logic [119:0]       cb_store_data;
  logic               cb_load;
  logic [3:0]         cb_d;
  logic               cb_valid = 1'b0;
  logic               cb_fin = 1'b0;
  logic [119:0]       cb_q = '0;

  always #5 clk = ~clk;

  cube_host #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STOP_ON_FIN(1'b1)) dut (
    .clk(clk), .rst(rst), .init_state(init_state), .mv_wr(mv_wr), .mv_data(mv_data),
    .mv_full(mv_full), .start(start), .busy(busy), .done(done), .solved(solved),
    .error(error), .moves_done(moves_done), .final_state(final_state),
    .cb_store(cb_store), .cb_store_data(cb_store_data), .cb_load(cb_load), .cb_d(cb_d),
    .cb_valid(cb_valid), .cb_fin(cb_fin), .cb_q(cb_q)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [119:0] act, input logic [119:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event occurred with nothing expected", name);
  endtask

  // Behaviour of the core as seen by the host: each move scrambles the state.
  function automatic logic [119:0] next_q(input logic [119:0] s, input logic [3:0] m);
    logic [239:0] d;
    int r;
    r = 4 * int'(m) + 1;
    d = {s, s} << r;
    return d[239:120] ^ {30{m}};
  endfunction

  typedef struct {
    int           md;
    bit           sol;
    bit           err;
    logic [119:0] fs;
    int           mode;   // 0: after last valid, 1: timeout after load, 2: empty start
  } res_t;

  logic [119:0] exp_store[$];
  logic [3:0]   exp_load[$];
  res_t         exp_res[$];
  logic [119:0] last_final = '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- core responder ----------------
  int           due = -1;
  int           load_idx = 0;
  bit           mute = 1'b0;
  int           lat_min = 3, lat_max = 3;
  bit           fin_pat [DEPTH];
  logic [3:0]   cur_mv = '0;
  logic [119:0] core_st = '0;

  always @(negedge clk) begin
    if (rst) begin
      due = -1;
    end else begin
      if (cb_store) begin
        core_st  = cb_store_data;
        load_idx = 0;
      end
      if (cb_load) begin
        cur_mv = cb_d;
        if (!mute) due = cyc + int'($urandom_range(lat_max, lat_min));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst && due == cyc) begin
      core_st  = next_q(core_st, cur_mv);
      cb_q     = core_st;
      cb_fin   = (load_idx < DEPTH) ? fin_pat[load_idx] : 1'b0;
      cb_valid = 1'b1;
      load_idx++;
      due      = -1;
    end else begin
      cb_valid = 1'b0;
      cb_fin   = 1'b0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int start_cyc = 0;
  int anchor = 0, last_load = 0, last_valid = 0;

  always @(negedge clk) begin
    res_t r;
    if (!rst) begin
      if (cb_store) begin
        if (exp_store.size() == 0) fail("unexpected_store");
        else check("store_data", cb_store_data, exp_store.pop_front());
        check("start_to_store", 120'(cyc - start_cyc), 120'd1);
        anchor = cyc;
      end
      if (cb_load) begin
        if (exp_load.size() == 0) fail("unexpected_load");
        else check("load_d", 120'(cb_d), 120'(exp_load.pop_front()));
        check("load_gap", 120'(cyc - anchor), 120'd2);
        last_load = cyc;
      end
      if (cb_valid) begin
        anchor     = cyc;
        last_valid = cyc;
      end
      if (done) begin
        if (exp_res.size() == 0) begin
          fail("unexpected_done");
        end else begin
          r = exp_res.pop_front();
          check("moves_done", 120'(moves_done), 120'(r.md));
          check("solved", 120'(solved), 120'(r.sol));
          check("error", 120'(error), 120'(r.err));
          check("final_state", final_state, r.fs);
          case (r.mode)
            0:       check("valid_to_done", 120'(cyc - last_valid), 120'd2);
            1:       check("load_to_done", 120'(cyc - last_load), 120'(TIMEOUT + 2));
            default: check("start_to_done", 120'(cyc - start_cyc), 120'd1);
          endcase
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [119:0] rand_state();
    logic [119:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) s = {s[87:0], 32'($urandom)};
    return s;
  endfunction

  task automatic push_mv(input logic [3:0] m);
    @(negedge clk);
    mv_wr   = 1'b1;
    mv_data = m;
    @(negedge clk);
    mv_wr   = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) fail("done_timeout");
    @(negedge clk);
    check("idle_after_done", 120'(busy), 120'd0);
  endtask

  task automatic run_seq(input logic [3:0] mv[$], input bit fins[$], input int lmin,
                         input int lmax, input bit mu, input bit push_on_start,
                         input bit busy_push);
    int           acc, n, npre, pushed;
    bit           stopped;
    logic [119:0] s, f;
    res_t         r;

    s = rand_state();
    mute = mu;
    lat_min = lmin;
    lat_max = lmax;
    for (int i = 0; i < DEPTH; i++) fin_pat[i] = (i < fins.size()) ? fins[i] : 1'b0;

    // Reference: first DEPTH writes are kept, run stops at the first finished move.
    acc = (mv.size() < DEPTH) ? mv.size() : DEPTH;
    if (acc == 0) begin
      r = '{md: 0, sol: 1'b0, err: 1'b0, fs: last_final, mode: 2};
    end else if (mu) begin
      exp_store.push_back(s);
      exp_load.push_back(mv[0]);
      r = '{md: 0, sol: 1'b0, err: 1'b1, fs: last_final, mode: 1};
    end else begin
      n = acc;
      stopped = 1'b0;
      for (int k = 0; k < acc; k++) begin
        if (!stopped && k < fins.size() && fins[k]) begin
          n = k + 1;
          stopped = 1'b1;
        end
      end
      exp_store.push_back(s);
      f = s;
      for (int k = 0; k < n; k++) begin
        exp_load.push_back(mv[k]);
        f = next_q(f, mv[k]);
      end
      r = '{md: n, sol: (n - 1 < fins.size()) ? fins[n-1] : 1'b0, err: 1'b0, fs: f, mode: 0};
      last_final = f;
    end
    exp_res.push_back(r);

    npre = (push_on_start && mv.size() > 0) ? mv.size() - 1 : mv.size();
    pushed = 0;
    for (int i = 0; i < npre; i++) begin
      push_mv(mv[i]);
      pushed++;
      check("mv_full", 120'(mv_full), 120'(pushed >= DEPTH));
    end

    init_state = s;
    @(negedge clk);
    start     = 1'b1;
    start_cyc = cyc;
    if (npre != mv.size()) begin
      mv_wr   = 1'b1;
      mv_data = mv[mv.size()-1];
    end
    @(negedge clk);
    start = 1'b0;
    mv_wr = 1'b0;
    if (busy_push) begin
      repeat (2) @(negedge clk);
      mv_wr   = 1'b1;
      mv_data = 4'hF;
      @(negedge clk);
      mv_wr   = 1'b0;
    end
    wait_done();
    mute = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 120'(busy), 120'd0);
    check({tag, "_done"}, 120'(done), 120'd0);
    check({tag, "_solved"}, 120'(solved), 120'd0);
    check({tag, "_error"}, 120'(error), 120'd0);
    check({tag, "_moves_done"}, 120'(moves_done), 120'd0);
    check({tag, "_final_state"}, final_state, 120'd0);
    check({tag, "_mv_full"}, 120'(mv_full), 120'd0);
    check({tag, "_cb_store"}, 120'(cb_store), 120'd0);
    check({tag, "_cb_store_data"}, cb_store_data, 120'd0);
    check({tag, "_cb_load"}, 120'(cb_load), 120'd0);
    check({tag, "_cb_d"}, 120'(cb_d), 120'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] mv[$];
    bit         fins[$];
    int         len, nloads;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Three moves, fixed latency, with a write attempted while busy.
    mv = '{4'd1, 4'd2, 4'd3};
    fins = {};
    run_seq(mv, fins, 3, 3, 1'b0, 1'b0, 1'b1);

    // Empty buffer: also proves the busy-time write was dropped.
    mv = {};
    run_seq(mv, fins, 3, 3, 1'b0, 1'b0, 1'b0);

    // Early stop on the second response.
    mv = '{4'd4, 4'd5, 4'd6, 4'd7};
    fins = '{1'b0, 1'b1};
    run_seq(mv, fins, 3, 3, 1'b0, 1'b0, 1'b0);
    mv = {};
    fins = {};
    run_seq(mv, fins, 3, 3, 1'b0, 1'b0, 1'b0);

    // Silent core: timeout, then the flushed buffer starts empty.
    mv = '{4'd9, 4'd10};
    run_seq(mv, fins, 3, 3, 1'b1, 1'b0, 1'b0);
    mv = {};
    run_seq(mv, fins, 3, 3, 1'b0, 1'b0, 1'b0);

    // Overfill: the seventeenth write is dropped.
    mv = {};
    for (int i = 0; i < DEPTH + 1; i++) mv.push_back(4'($urandom_range(12, 1)));
    run_seq(mv, fins, 1, 4, 1'b0, 1'b0, 1'b0);

    // Random sequences with random latency and finish flags.
    for (int t = 0; t < 6; t++) begin
      mv = {};
      fins = {};
      len = $urandom_range(DEPTH, 1);
      for (int i = 0; i < len; i++) begin
        mv.push_back(4'($urandom));
        fins.push_back($urandom_range(4, 0) == 0);
      end
      run_seq(mv, fins, 1, 6, 1'b0, bit'($urandom_range(1, 0)), 1'b0);
    end

    // Reset in the WAIT of the second move.
    mute = 1'b0;
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < DEPTH; i++) fin_pat[i] = 1'b0;
    init_state = rand_state();
    exp_store.push_back(init_state);
    exp_load.push_back(4'd1);
    exp_load.push_back(4'd2);
    mv = '{4'd1, 4'd2, 4'd3, 4'd4};
    foreach (mv[i]) push_mv(mv[i]);
    @(negedge clk);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    nloads = 0;
    for (int t = 0; t < 200 && nloads < 2; t++) begin
      if (cb_load) nloads++;
      if (nloads < 2) @(negedge clk);
    end
    check("second_load_seen", 120'(nloads), 120'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    check("loads_before_reset", 120'(exp_load.size()), 120'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_final = '0;

    mv = '{4'd11, 4'd12, 4'd3};
    fins = {};
    run_seq(mv, fins, 2, 4, 1'b0, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    check("pending_store", 120'(exp_store.size()), 120'd0);
    check("pending_load", 120'(exp_load.size()), 120'd0);
    check("pending_result", 120'(exp_res.size()), 120'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
